// File: rtl/rram_mac_sequencer.sv
// Sequences wordline groups, ADC conversions and per-column accumulation for an RRAM MAC array.
// Each group is PRECH, SETTLE, CONV and CAPT; each column ends with a one-cycle EMIT of its sum.
module rram_mac_sequencer #(
  parameter int ARRAY_SIZE = 16,
  parameter int GROUP      = 4,
  parameter int SETTLE     = 2,
  parameter int ADC_CYC    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            col_start,
  input  logic [3:0]            col_end,
  input  logic [3:0]            row_start,
  input  logic [3:0]            row_end,
  input  logic [3:0]            adc_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ARRAY_SIZE-1:0] wl_en,
  output logic [3:0]            col_sel,
  output logic                  pre,
  output logic                  clk_en_adc,
  output logic [7:0]            acc_out,
  output logic                  acc_valid,
  output logic [2:0]            dbg_state
);

  localparam int GW   = $clog2(ARRAY_SIZE) + 1;
  localparam int CMAX = (SETTLE > ADC_CYC) ? SETTLE : ADC_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRECH, S_SETTLE, S_CONV, S_CAPT, S_EMIT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [3:0]      col, col_end_q, row_start_q, row_end_q;
  logic [GW-1:0]   grp, grp_hi;
  logic [7:0]      acc;
  logic            err_q;
  logic            win_ok, accept, reject, more_grp, more_col;
  logic            settle_last, conv_last;
  logic [ARRAY_SIZE-1:0] wl_mask;

  assign win_ok      = (col_start <= col_end) && (row_start <= row_end);
  assign accept      = (state == S_IDLE) && start && !abort && win_ok;
  assign reject      = (state == S_IDLE) && start && !abort && !win_ok;
  // Group arithmetic is one bit wider than a row index so grp+GROUP cannot wrap past row 15.
  assign more_grp    = (grp + GW'(GROUP)) <= GW'(row_end_q);
  assign more_col    = col < col_end_q;
  assign settle_last = cnt == CW'(SETTLE - 1);
  assign conv_last   = cnt == CW'(ADC_CYC - 1);
  assign grp_hi      = grp + GW'(GROUP - 1);

  always_comb begin
    wl_mask = '0;
    for (int r = 0; r < ARRAY_SIZE; r++) begin
      wl_mask[r] = (GW'(r) >= grp) && (GW'(r) <= grp_hi) && (GW'(r) <= GW'(row_end_q));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state != S_IDLE && abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_n = S_PRECH;
        S_PRECH:  state_n = S_SETTLE;
        S_SETTLE: if (settle_last) state_n = S_CONV;
        S_CONV:   if (conv_last) state_n = S_CAPT;
        S_CAPT:   state_n = more_grp ? S_PRECH : S_EMIT;
        S_EMIT:   state_n = more_col ? S_PRECH : S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // acc_valid qualifies acc_out and col_sel for exactly one cycle; there is no back-pressure,
  // and an abort seen during EMIT suppresses both acc_valid and done.
  always_comb begin
    busy       = 1'b0;
    pre        = 1'b0;
    clk_en_adc = 1'b0;
    wl_en      = '0;
    acc_valid  = 1'b0;
    acc_out    = '0;
    done       = 1'b0;
    case (state)
      S_PRECH:  begin busy = 1'b1; pre = 1'b1; end
      S_SETTLE: begin busy = 1'b1; wl_en = wl_mask; end
      S_CONV:   begin busy = 1'b1; wl_en = wl_mask; clk_en_adc = 1'b1; end
      S_CAPT:   begin busy = 1'b1; wl_en = wl_mask; end
      S_EMIT: begin
        busy      = 1'b1;
        acc_valid = !abort;
        acc_out   = abort ? 8'd0 : acc;
        done      = !abort && !more_col;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      col         <= '0;
      grp         <= '0;
      acc         <= '0;
      col_end_q   <= '0;
      row_start_q <= '0;
      row_end_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= reject;
      cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
      if (accept) begin
        col         <= col_start;
        grp         <= GW'(row_start);
        acc         <= '0;
        col_end_q   <= col_end;
        row_start_q <= row_start;
        row_end_q   <= row_end;
      end else if (!abort) begin
        case (state)
          S_CAPT: begin
            acc <= acc + 8'(adc_data);
            if (more_grp) grp <= grp + GW'(GROUP);
          end
          S_EMIT: begin
            if (more_col) begin
              col <= col + 4'd1;
              grp <= GW'(row_start_q);
              acc <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign err       = err_q;
  assign col_sel   = col;
  assign dbg_state = state;

endmodule

// File: tb/tb_rram_mac_sequencer.sv
// Bench for rram_mac_sequencer: a per-cycle timeline model built from the window rules,
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_rram_mac_sequencer;

  localparam int GROUP   = 4;
  localparam int SETTLE  = 2;
  localparam int ADC_CYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  col_start = '0, col_end = '0, row_start = '0, row_end = '0, adc_data = '0;
  logic        busy, done, err, pre, clk_en_adc, acc_valid;
  logic [15:0] wl_en;
  logic [3:0]  col_sel;
  logic [7:0]  acc_out;
  logic [2:0]  dbg_state;

  rram_mac_sequencer #(.ARRAY_SIZE(16), .GROUP(GROUP), .SETTLE(SETTLE), .ADC_CYC(ADC_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .col_start(col_start), .col_end(col_end), .row_start(row_start), .row_end(row_end),
    .adc_data(adc_data), .busy(busy), .done(done), .err(err), .wl_en(wl_en),
    .col_sel(col_sel), .pre(pre), .clk_en_adc(clk_en_adc), .acc_out(acc_out),
    .acc_valid(acc_valid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        pre;
    logic        cea;
    logic [15:0] wl;
    logic        capt;
    logic        emit;
    logic        last;
    logic [3:0]  col;
  } ent_t;

  ent_t       sched[$];
  logic [7:0] m_acc = '0;
  logic       m_err = 1'b0;
  logic [3:0] m_col_last = '0;
  logic [2:0] idle_code = '0;

  function automatic ent_t cur_ent();
    ent_t e;
    e = '0;
    if (sched.size() > 0) e = sched[0];
    return e;
  endfunction

  // One entry per cycle the operation will take, straight from the window rules.
  task automatic build(input int cs, input int ce, input int rs, input int re);
    ent_t e;
    logic [15:0] m;
    for (int c = cs; c <= ce; c++) begin
      for (int g = rs; g <= re; g += GROUP) begin
        m = '0;
        for (int r = g; r <= re && r < g + GROUP; r++) m[r] = 1'b1;
        e = '0; e.col = 4'(c); e.pre = 1'b1;
        sched.push_back(e);
        e.pre = 1'b0; e.wl = m;
        repeat (SETTLE) sched.push_back(e);
        e.cea = 1'b1;
        repeat (ADC_CYC) sched.push_back(e);
        e.cea = 1'b0; e.capt = 1'b1;
        sched.push_back(e);
      end
      e = '0; e.col = 4'(c); e.emit = 1'b1; e.last = (c == ce);
      sched.push_back(e);
    end
  endtask

  initial begin
    ent_t cur;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        sched.delete();
        m_acc = '0;
        m_err = 1'b0;
        m_col_last = '0;
      end else begin
        m_err = 1'b0;
        if (sched.size() > 0) begin
          cur = sched[0];
          if (cur.capt) m_acc = m_acc + 8'(adc_data);
          if (abort) begin
            sched.delete();
            m_acc = '0;
          end else begin
            if (cur.emit) m_acc = '0;
            void'(sched.pop_front());
          end
        end else if (start && !abort) begin
          if (col_start <= col_end && row_start <= row_end) begin
            build(int'(col_start), int'(col_end), int'(row_start), int'(row_end));
            m_acc = '0;
          end else begin
            m_err = 1'b1;
          end
        end
        if (sched.size() > 0) m_col_last = sched[0].col;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0]  emit_acc[$];
  logic [3:0]  emit_col[$];
  logic [15:0] wl_seen[$];
  logic [15:0] prev_wl = '0;
  int n_done = 0, n_err = 0, n_busy = 0, done_cyc = 0, start_cyc = 0;

  initial begin
    ent_t c;
    logic exp_busy, exp_av;
    forever begin
      @(negedge clk);
      c = cur_ent();
      exp_busy = sched.size() > 0;
      exp_av   = c.emit && !abort;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("pre", 32'(pre), 32'(c.pre));
      chk("clk_en_adc", 32'(clk_en_adc), 32'(c.cea));
      chk("wl_en", 32'(wl_en), 32'(c.wl));
      chk("acc_valid", 32'(acc_valid), 32'(exp_av));
      chk("done", 32'(done), 32'(exp_av && c.last));
      chk("err", 32'(err), 32'(m_err));
      chk("col_sel", 32'(col_sel), 32'(exp_busy ? c.col : m_col_last));
      chk("dbg_state_idle", 32'(dbg_state == idle_code), 32'(!exp_busy));
      if (exp_av) chk("acc_out", 32'(acc_out), 32'(m_acc));
      if (acc_valid) begin
        emit_acc.push_back(acc_out);
        emit_col.push_back(col_sel);
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_err++;
      if (busy) n_busy++;
      if (wl_en != 16'h0 && prev_wl == 16'h0) wl_seen.push_back(wl_en);
      prev_wl = wl_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    emit_acc.delete(); emit_col.delete(); wl_seen.delete();
    n_done = 0; n_err = 0; n_busy = 0; done_cyc = 0;
  endtask

  task automatic do_start(input logic [3:0] cs, input logic [3:0] ce,
                          input logic [3:0] rs, input logic [3:0] re);
    @(posedge clk); #1;
    start = 1'b1; col_start = cs; col_end = ce; row_start = rs; row_end = re;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic run_dir(input logic [3:0] cs, input logic [3:0] ce, input logic [3:0] rs,
                         input logic [3:0] re, input logic [3:0] adc, input int lat);
    clear_obs();
    adc_data = adc;
    do_start(cs, ce, rs, re);
    wait_idle(200);
    chk("done_count", 32'(n_done), 32'(1));
    chk("done_latency", 32'(done_cyc - start_cyc), 32'(lat));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cs, ce, rs, re;
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_code = dbg_state;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wl_en", 32'(wl_en), 32'(0));
    chk("rst_col_sel", 32'(col_sel), 32'(0));
    chk("rst_acc_out", 32'(acc_out), 32'(0));
    chk("rst_done_err", 32'({done, err, acc_valid, pre, clk_en_adc}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Single group, single column; start arrives right after reset release.
    clear_obs();
    adc_data = 4'd5;
    start = 1'b1; col_start = 4'd2; col_end = 4'd2; row_start = 4'd0; row_end = 4'd3;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(200);
    chk("w1_done_latency", 32'(done_cyc - start_cyc), 32'(9));
    chk("w1_emits", 32'(emit_acc.size()), 32'(1));
    if (emit_acc.size() == 1) begin
      chk("w1_acc", 32'(emit_acc[0]), 32'(5));
      chk("w1_col", 32'(emit_col[0]), 32'(2));
    end
    chk("w1_groups", 32'(wl_seen.size()), 32'(1));
    if (wl_seen.size() == 1) chk("w1_wl", 32'(wl_seen[0]), 32'h000F);

    // Two full columns of four groups each.
    run_dir(4'd0, 4'd1, 4'd0, 4'd15, 4'd15, 66);
    chk("w2_emits", 32'(emit_acc.size()), 32'(2));
    if (emit_acc.size() == 2) begin
      chk("w2_acc0", 32'(emit_acc[0]), 32'(60));
      chk("w2_acc1", 32'(emit_acc[1]), 32'(60));
      chk("w2_col0", 32'(emit_col[0]), 32'(0));
      chk("w2_col1", 32'(emit_col[1]), 32'(1));
    end
    chk("w2_groups", 32'(wl_seen.size()), 32'(8));
    if (wl_seen.size() == 8) begin
      chk("w2_wl0", 32'(wl_seen[0]), 32'h000F);
      chk("w2_wl1", 32'(wl_seen[1]), 32'h00F0);
      chk("w2_wl2", 32'(wl_seen[2]), 32'h0F00);
      chk("w2_wl3", 32'(wl_seen[3]), 32'hF000);
    end

    // Partial group at the top rows.
    run_dir(4'd3, 4'd3, 4'd13, 4'd14, 4'd7, 9);
    if (wl_seen.size() == 1) chk("w3_wl", 32'(wl_seen[0]), 32'h6000);
    else chk("w3_groups", 32'(wl_seen.size()), 32'(1));
    if (emit_acc.size() == 1) chk("w3_acc", 32'(emit_acc[0]), 32'(7));

    // Rejected window.
    clear_obs();
    do_start(4'd5, 4'd3, 4'd0, 4'd3);
    repeat (3) @(negedge clk);
    chk("rej_err_pulses", 32'(n_err), 32'(1));
    chk("rej_busy", 32'(n_busy), 32'(0));
    chk("rej_wl", 32'(wl_seen.size()), 32'(0));

    // Abort during CONV of the second group.
    clear_obs();
    adc_data = 4'd9;
    do_start(4'd0, 4'd0, 4'd0, 4'd7);
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_in_conv", 32'(clk_en_adc), 32'(1));
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_cea", 32'(clk_en_adc), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    chk("abort_emits", 32'(emit_acc.size()), 32'(0));
    chk("abort_done", 32'(n_done), 32'(0));
    run_dir(4'd1, 4'd1, 4'd0, 4'd7, 4'd4, 17);
    if (emit_acc.size() == 1) chk("after_abort_acc", 32'(emit_acc[0]), 32'(8));

    // Reset pulled mid-SETTLE, checked before any clock edge.
    clear_obs();
    adc_data = 4'd6;
    do_start(4'd5, 4'd5, 4'd0, 4'd3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_wl_en", 32'(wl_en), 32'(0));
    chk("arst_col_sel", 32'(col_sel), 32'(0));
    chk("arst_misc", 32'({pre, clk_en_adc, acc_valid, done, err, acc_out}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    run_dir(4'd4, 4'd4, 4'd4, 4'd11, 4'd6, 17);
    if (emit_acc.size() == 1) chk("after_rst_acc", 32'(emit_acc[0]), 32'(12));

    // Randomized traffic: sparse starts, occasional bad windows and aborts.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      adc_data = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 199) == 0);
      cs = $urandom_range(0, 15);
      rs = $urandom_range(0, 15);
      ce = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : cs + $urandom_range(0, 1);
      re = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : rs + $urandom_range(0, 7);
      if (ce > 15) ce = 15;
      if (re > 15) re = 15;
      col_start = 4'(cs); col_end = 4'(ce); row_start = 4'(rs); row_end = 4'(re);
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    wait_idle(2000);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rram_mac_sequencer.md
RRAM_MAC_SEQUENCER -- requirements
Module: rram_mac_sequencer

Interface
REQ-001 Parameters (name, default, meaning): ARRAY_SIZE, 16, array rows/columns; GROUP, 4, wordlines enabled per MAC step; SETTLE, 2, cycles of WL drive before conversion; ADC_CYC, 4, ADC clock-enable cycles per conversion.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle MAC request strobe.
REQ-005 abort  input  1  cancel the current operation.
REQ-006 col_start, col_end, row_start, row_end  input  4 each  inclusive MAC window; sampled only on an accepted start.
REQ-007 adc_data  input  4  ADC result for the selected column.
REQ-008 busy  output  1  high from the cycle after an accepted start until IDLE.
REQ-009 done  output  1  one-cycle pulse when the whole window completes.
REQ-010 err  output  1  one-cycle pulse when a start is rejected.
REQ-011 wl_en  output  ARRAY_SIZE  wordline enables.
REQ-012 col_sel  output  4  active column index to the column mux.
REQ-013 pre  output  1  bitline precharge, active high.
REQ-014 clk_en_adc  output  1  ADC clock enable.
REQ-015 acc_out  output  8  per-column accumulated MAC sum.
REQ-016 acc_valid  output  1  one-cycle qualifier for acc_out and col_sel.

Function
REQ-017 States: IDLE, PRECH, SETTLE, CONV, CAPT, EMIT.
REQ-018 IDLE outputs: wl_en=0, pre=0, clk_en_adc=0, busy=0.
REQ-019 Start acceptance: in IDLE, start with col_start<=col_end and row_start<=row_end latches the window, sets col=col_start, grp=row_start, acc=0, and moves to PRECH.
REQ-020 Start rejection: in IDLE, start with col_start>col_end or row_start>row_end pulses err next cycle and stays in IDLE.
REQ-021 Start while busy: ignored, with no err and no effect.
REQ-022 PRECH: lasts 1 cycle; pre=1, wl_en=0; then SETTLE.
REQ-023 SETTLE: lasts SETTLE cycles; pre=0; wl_en[r]=1 exactly for rows r in [grp, min(grp+GROUP-1, row_end)]; then CONV.
REQ-024 CONV: lasts ADC_CYC cycles; clk_en_adc=1; wl_en held; then CAPT.
REQ-025 CAPT: lasts 1 cycle; wl_en held; acc += zero-extended adc_data.
REQ-026 After CAPT: if grp+GROUP<=row_end, set grp+=GROUP and go to PRECH; otherwise go to EMIT.
REQ-027 EMIT: lasts 1 cycle; wl_en=0; acc_out=acc, acc_valid=1, col_sel=col.
REQ-028 After EMIT: if col<col_end, set col+=1, grp=row_start, acc=0 and go to PRECH; otherwise pulse done in the same cycle and go to IDLE.
REQ-029 col_sel equals col in every non-IDLE state and holds its last value in IDLE.
REQ-030 Group cycle cost is 1+SETTLE+ADC_CYC+1 (8 at defaults).
REQ-031 Total latency is ncol*(ngrp*8+1) cycles from the start edge to the done pulse, where ngrp=ceil((row_end-row_start+1)/GROUP).
REQ-032 Accumulator is 8 bits and never overflows for ARRAY_SIZE=16 (max 4*15=60); group-index arithmetic uses 5 bits so grp+GROUP does not wrap at row 15.
REQ-033 abort in any non-IDLE state: next cycle IDLE, all outputs at IDLE values, done and acc_valid not asserted.
REQ-034 abort has priority over start in the same cycle.
REQ-035 abort in IDLE has no effect.

Reset
REQ-036 rst low: immediately force IDLE and the outputs wl_en=0, col_sel=0, pre=0, clk_en_adc=0, acc_out=0, acc_valid=0, busy=0, done=0, err=0, regardless of clock.
REQ-037 rst low also clears acc, col and grp.
REQ-038 Reset asserted mid-operation discards the operation; there is no resume after deassertion.
REQ-039 The first start is accepted on the first rising edge after rst deasserts.

Verification
REQ-040 Window col 2..2, row 0..3, adc_data=5 -> wl_en=0x000F during SETTLE and CONV; one acc_valid with col_sel=2, acc_out=5; done 9 cycles after start.
REQ-041 Window col 0..1, row 0..15, adc_data=15 -> 4 groups per column with wl_en 0x000F, 0x00F0, 0x0F00, 0xF000; acc_out=60 twice (col_sel 0 then 1); done 66 cycles after start.
REQ-042 Window row 13..14 -> single group with wl_en=0x6000 (partial group); grp does not wrap.
REQ-043 Start with col_start=5, col_end=3 -> err pulse for 1 cycle, busy stays 0, wl_en stays 0.
REQ-044 Abort during CONV of the second group -> IDLE next cycle, clk_en_adc=0, no acc_valid, no done; a new start is then accepted normally.
REQ-045 rst asserted low mid-SETTLE -> all outputs zero without a clock edge; after release, a start runs the full sequence with acc beginning at 0.
